// File: rtl/ad9253_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad9253_cfg_pkg
// Brief    : Types, register map and write table constants for the AD9253
//            power-up configuration sequencer. AD9253_TESTPATTERN_EN selects
//            the checkerboard test mode for table entry 3.
// Revision : 1.0 - initial release
// ============================================================================
package ad9253_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_WAIT_RST = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  w;
        logic [12:0] addr;
        logic [7:0]  data;
    } spi_frame_t;

    localparam logic [12:0] c_addr_soft_reset = 13'h000;
    localparam logic [12:0] c_addr_out_format = 13'h014;
    localparam logic [12:0] c_addr_lane_mode  = 13'h021;
    localparam logic [12:0] c_addr_test_mode  = 13'h00D;
    localparam logic [12:0] c_addr_transfer   = 13'h0FF;

    localparam logic [7:0] c_data_soft_reset = 8'h3C;
    localparam logic [7:0] c_data_out_format = 8'h01;
    localparam logic [7:0] c_data_lane_mode  = 8'h30;
`ifdef AD9253_TESTPATTERN_EN
    // Checkerboard lets the deserializer bit/frame-align on a known pattern.
    localparam logic [7:0] c_data_test_mode  = 8'h04;
`else
    localparam logic [7:0] c_data_test_mode  = 8'h00;
`endif
    localparam logic [7:0] c_data_transfer   = 8'h01;

    localparam int unsigned c_table_len = 5;
    localparam logic [2:0]  c_last_step = 3'(c_table_len - 1);

    function automatic spi_frame_t make_write(input logic [12:0] addr, input logic [7:0] data);
        spi_frame_t f;
        f.rw   = 1'b0;
        f.w    = 2'b00;
        f.addr = addr;
        f.data = data;
        return f;
    endfunction

endpackage : ad9253_cfg_pkg
`default_nettype wire

// File: rtl/spi_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_shifter
// Brief    : Shifts one 24-bit 3-wire SPI write frame, MSB first, with SCLK
//            divider and bit counter; frame_done marks the frame's last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_shifter
    import ad9253_cfg_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       load,
    input  spi_frame_t frame,
    output logic       csb,
    output logic       sclk,
    output logic       sdio,
    output logic       frame_done
);

    localparam logic [7:0] c_div_last = 8'(SCLK_DIV - 1);

    logic        r_active;
    logic [7:0]  r_div;
    logic [4:0]  r_bit;
    logic [23:0] r_shift;
    logic        r_sclk;
    logic        w_half_end;

    assign w_half_end = (r_div == c_div_last);

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b0;
        end else if (load) begin
            r_active <= 1'b1;
            r_div    <= '0;
            r_bit    <= 5'd23;
            r_shift  <= frame;
            r_sclk   <= 1'b0;
        end else if (r_active) begin
            if (w_half_end) begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
                // Data advances only on the falling edge; the ADC samples on rising.
                if (r_sclk) begin
                    r_shift <= {r_shift[22:0], 1'b0};
                    if (r_bit == 5'd0) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit - 5'd1;
                    end
                end
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    assign csb        = ~r_active;
    assign sclk       = r_sclk;
    assign sdio       = r_shift[23];
    assign frame_done = r_active & r_sclk & w_half_end & (r_bit == 5'd0);

endmodule : spi_frame_shifter
`default_nettype wire

// File: rtl/ad9253_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ad9253_cfg_sequencer
// Brief    : Power-up SPI write sequencer for the AD9253 control port. Entry 3
//            data depends on AD9253_TESTPATTERN_EN (see ad9253_cfg_pkg).
// Revision : 1.0 - initial release
// ============================================================================
module ad9253_cfg_sequencer
    import ad9253_cfg_pkg::*;
#(
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned RESET_WAIT = 10000,
    parameter int unsigned CSB_GAP    = 4
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       start,
    output logic       csb,
    output logic       sclk,
    output logic       sdio,
    output logic       busy,
    output logic       done,
    output logic [2:0] step
);

    localparam logic [19:0] c_wait_last = 20'(RESET_WAIT - 1);
    localparam logic [19:0] c_gap_last  = 20'(CSB_GAP - 1);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [2:0]  r_step;
    logic [19:0] r_cnt;
    logic        w_load;
    logic        w_frame_done;
    spi_frame_t  w_frame;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            // IDLE is only ever entered through reset, so it always proceeds.
            ST_IDLE:     w_next = ST_LOAD;
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_frame_done) begin
                    if (r_step == 3'd0) begin
                        w_next = ST_WAIT_RST;
                    end else if (r_step == c_last_step) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_GAP;
                    end
                end
            end
            ST_WAIT_RST: if (r_cnt == c_wait_last) w_next = ST_LOAD;
            ST_GAP:      if (r_cnt == c_gap_last)  w_next = ST_LOAD;
            ST_DONE:     if (start)                w_next = ST_LOAD;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_step <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_state != ST_LOAD && w_next == ST_LOAD) begin
                if (r_state == ST_IDLE || r_state == ST_DONE) begin
                    r_step <= '0;
                end else begin
                    r_step <= r_step + 3'd1;
                end
            end
            if ((r_state == ST_WAIT_RST || r_state == ST_GAP) && w_next == r_state) begin
                r_cnt <= r_cnt + 20'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_frame = '0;
        case (r_step)
            3'd0:    w_frame = make_write(c_addr_soft_reset, c_data_soft_reset);
            3'd1:    w_frame = make_write(c_addr_out_format, c_data_out_format);
            3'd2:    w_frame = make_write(c_addr_lane_mode,  c_data_lane_mode);
            3'd3:    w_frame = make_write(c_addr_test_mode,  c_data_test_mode);
            default: w_frame = make_write(c_addr_transfer,   c_data_transfer);
        endcase
    end

    spi_frame_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .load       (w_load),
        .frame      (w_frame),
        .csb        (csb),
        .sclk       (sclk),
        .sdio       (sdio),
        .frame_done (w_frame_done)
    );

    assign busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done = (r_state == ST_DONE);
    assign step = r_step;

endmodule : ad9253_cfg_sequencer
`default_nettype wire

// File: tb/tb_ad9253_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9253_cfg_sequencer
// Brief    : Self-checking bench: SPI capture model, frame table and timing
//            formula checked across reset, ignored starts, restart and abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad9253_cfg_sequencer;

    localparam int D         = 4;
    localparam int RW        = 10000;
    localparam int G         = 4;
    localparam int FRAME_CYC = 48 * D;
    // Edges from the edge that enters the first LOAD (or IDLE) to DONE.
    localparam int DONE_LAT  = 1 + 5 * (1 + FRAME_CYC) + RW + 3 * G;
`ifdef AD9253_TESTPATTERN_EN
    localparam logic [7:0] TP_DATA = 8'h04;
`else
    localparam logic [7:0] TP_DATA = 8'h00;
`endif

    logic       clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic       start = 1'b0;
    logic       csb, sclk, sdio, busy, done;
    logic [2:0] step;

    ad9253_cfg_sequencer #(
        .SCLK_DIV   (D),
        .RESET_WAIT (RW),
        .CSB_GAP    (G)
    ) dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .start (start),
        .csb   (csb),
        .sclk  (sclk),
        .sdio  (sdio),
        .busy  (busy),
        .done  (done),
        .step  (step)
    );

    always #50 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_frame(input int idx);
        logic [12:0] a;
        logic [7:0]  d;
        case (idx)
            0:       begin a = 13'h000; d = 8'h3C;   end
            1:       begin a = 13'h014; d = 8'h01;   end
            2:       begin a = 13'h021; d = 8'h30;   end
            3:       begin a = 13'h00D; d = TP_DATA; end
            default: begin a = 13'h0FF; d = 8'h01;   end
        endcase
        return {1'b0, 2'b00, a, d};
    endfunction

    // SPI slave model: captures frames on sclk rising edges and times csb.
    logic [23:0] cap_q[$];
    int          mon_frames = 0;
    int          mon_rises  = 0;
    int          clear_req  = 0;
    initial begin
        int          clear_ack = 0;
        int          low = 0, high = 0;
        bit          in_frame = 0, have_rise = 0;
        logic [23:0] sr = '0;
        logic        p_csb = 1'b1, p_sclk = 1'b0, p_sdio = 1'b0;
        forever begin
            @(negedge clk);
            if (clear_req != clear_ack) begin
                cap_q.delete();
                clear_ack = clear_req;
                in_frame  = 0;
                have_rise = 0;
            end
            if (!Rst_n) begin
                in_frame  = 0;
                have_rise = 0;
                mon_rises = 0;
            end else begin
                if (p_csb && !csb) begin
                    if (have_rise) begin
                        if (cap_q.size() == 1) check_val("reset_gap_min", (high >= RW) ? 1 : 0, 1);
                        else                   check_val("csb_gap", high, G + 1);
                    end
                    check_val("step_at_frame", step, cap_q.size());
                    in_frame  = 1;
                    low       = 0;
                    mon_rises = 0;
                    sr        = '0;
                end
                if (!csb && in_frame) begin
                    low++;
                    if (!p_sclk && sclk) begin
                        sr = {sr[22:0], sdio};
                        mon_rises++;
                    end
                    if (p_sclk && sclk) check_val("sdio_stable", sdio, p_sdio);
                end
                if (!p_csb && csb && in_frame) begin
                    check_val("csb_low_len", low, FRAME_CYC);
                    check_val("sclk_rises", mon_rises, 24);
                    cap_q.push_back(sr);
                    in_frame  = 0;
                    have_rise = 1;
                    high      = 0;
                end
                if (csb) high++;
            end
            p_csb      = csb;
            p_sclk     = sclk;
            p_sdio     = sdio;
            mon_frames = cap_q.size();
        end
    end

    task automatic wait_done(input string tag, input int unsigned s);
        while (!done && (cyc - s) < DONE_LAT + 100) @(negedge clk);
        check_val({tag, "_done_lat"}, cyc - s, DONE_LAT);
        check_val({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    task automatic check_frames(input string tag);
        repeat (2) @(negedge clk);
        check_val({tag, "_count"}, cap_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap_q.size()) check_val($sformatf("%s_frame%0d", tag, i), cap_q[i], exp_frame(i));
        end
    endtask

    task automatic wait_bit(input string tag, input int nf, input int nr);
        int n = 0;
        while (!(mon_frames == nf && !csb && mon_rises == nr) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check_val({tag, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_csb"},  csb,  1'b1);
        check_val({tag, "_sclk"}, sclk, 1'b0);
        check_val({tag, "_sdio"}, sdio, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_done"}, done, 1'b0);
        check_val({tag, "_step"}, step, 3'd0);
    endtask

    initial begin
        int unsigned s;
        int          n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Undisturbed sequence from reset release.
        clear_req++;
        repeat (2) @(negedge clk);
        Rst_n = 1'b1;
        s = cyc;
        wait_done("run_a", s);
        check_frames("run_a");

        // Restart from DONE, with start pulses while busy that must be ignored.
        repeat ($urandom_range(1, 20)) @(negedge clk);
        clear_req++;
        repeat (2) @(negedge clk);
        s = cyc;
        pulse_start();
        check_val("restart_done_drop", done, 1'b0);
        check_val("restart_busy", busy, 1'b1);
        check_val("restart_step", step, 3'd0);
        n = 0;
        while (mon_frames != 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat ($urandom_range(10, 9000)) @(negedge clk);
        pulse_start();
        wait_bit("run_b_f2b10", 2, 11);
        pulse_start();
        wait_done("run_b", s);
        check_frames("run_b");

        // Reset asserted mid-frame aborts; the sequence restarts from entry 0.
        repeat ($urandom_range(1, 20)) @(negedge clk);
        clear_req++;
        repeat (2) @(negedge clk);
        pulse_start();
        wait_bit("run_c_f1b12", 1, 13);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat ($urandom_range(1, 6)) @(negedge clk);
        clear_req++;
        repeat (2) @(negedge clk);
        Rst_n = 1'b1;
        s = cyc;
        wait_done("run_c", s);
        check_frames("run_c");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ad9253_cfg_sequencer
`default_nettype wire
